// File: rtl/input_conditioner_pkg.sv
// Shared direction bit positions, rotation encoding and direction helpers
// for the input conditioner and its per-player direction filter.
package input_conditioner_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        ROT_NONE = 2'b00,
        ROT_CW   = 2'b01,
        ROT_CCW  = 2'b10,
        ROT_180  = 2'b11
    } rot_t;

    function automatic logic [3:0] rotate_dir(input rot_t r, input logic [3:0] d);
        logic [3:0] res;
        case (r)
            ROT_CW:  res = {d[DIR_LEFT],  d[DIR_RIGHT], d[DIR_DOWN],  d[DIR_UP]};
            ROT_CCW: res = {d[DIR_RIGHT], d[DIR_LEFT],  d[DIR_UP],    d[DIR_DOWN]};
            ROT_180: res = {d[DIR_DOWN],  d[DIR_UP],    d[DIR_RIGHT], d[DIR_LEFT]};
            default: res = d;
        endcase
        return res;
    endfunction

    // Priority up > down > left > right when several directions arrive together.
    function automatic logic [3:0] onehot_msb(input logic [3:0] v);
        logic [3:0] res;
        casez (v)
            4'b1???: res = 4'b1000;
            4'b01??: res = 4'b0100;
            4'b001?: res = 4'b0010;
            4'b0001: res = 4'b0001;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/input_conditioner_dir.sv
// Per-player direction filter: 4-way last-pressed-wins mask, 8-way SOCD
// cancellation, or plain pass-through; output is registered.
module dir_filter
    import input_conditioner_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [3:0] cur,
    input  logic       dis,
    input  logic       mode8,
    input  logic       force_open,
    output logic [3:0] dir_out
);

    logic [3:0] prev_reg;
    logic [3:0] mask_reg;
    logic [3:0] mask_next;
    logic [3:0] new_bits;
    logic [3:0] out_next;

    always_comb begin
        new_bits  = cur & ~prev_reg;
        mask_next = mask_reg;
        out_next  = cur;

        if (dis || mode8 || force_open) begin
            mask_next = 4'b1111;
        end else if (new_bits != 4'b0000) begin
            mask_next = onehot_msb(new_bits);
        end else if ((cur & mask_reg) == 4'b0000) begin
            // newest direction released: fall back to whatever is still held
            mask_next = 4'b1111;
        end

        if (dis) begin
            out_next = cur;
        end else if (mode8) begin
            if (cur[DIR_UP] && cur[DIR_DOWN]) begin
                out_next[DIR_UP]   = 1'b0;
                out_next[DIR_DOWN] = 1'b0;
            end
            if (cur[DIR_LEFT] && cur[DIR_RIGHT]) begin
                out_next[DIR_LEFT]  = 1'b0;
                out_next[DIR_RIGHT] = 1'b0;
            end
        end else begin
            out_next = cur & mask_next;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= 4'b0000;
            mask_reg <= 4'b1111;
            dir_out  <= 4'b0000;
        end else begin
            prev_reg <= cur;
            mask_reg <= mask_next;
            dir_out  <= out_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Multi-player input conditioner: sync, rotation, direction filtering, button
// debounce and coin pulses. Autofire is added by INPUT_CONDITIONER_AUTOFIRE_EN.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned PLAYERS  = 2,
    parameter int unsigned DEB_CNT  = 20000,
    parameter int unsigned COIN_LEN = 40000
`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
    ,
    parameter int unsigned AF_HALF  = 1000000
`endif
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 dis,
    input  logic [1:0]           rot,
    input  logic                 mode8,
    input  logic [4*PLAYERS-1:0] dir_in,
    input  logic [4*PLAYERS-1:0] btn_in,
    input  logic [PLAYERS-1:0]   coin_in,
    input  logic [4*PLAYERS-1:0] af_sel,
    output logic [4*PLAYERS-1:0] dir_out,
    output logic [4*PLAYERS-1:0] btn_out,
    output logic [PLAYERS-1:0]   coin_out
);

    localparam int unsigned NB     = 4 * PLAYERS;
    localparam int unsigned DEB_W  = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;
    localparam int unsigned COIN_W = $clog2(COIN_LEN + 1);

    logic [NB-1:0]      dir_s1_reg, dir_s2_reg;
    logic [NB-1:0]      btn_s1_reg, btn_s2_reg;
    logic [PLAYERS-1:0] coin_s1_reg, coin_s2_reg, coin_prev_reg;
    logic [1:0]         rot_reg;
    logic               mode8_reg;
    logic               force_open;
    logic [NB-1:0]      deb_vec;
    logic [NB-1:0]      deb_next;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_s1_reg    <= '0;
            dir_s2_reg    <= '0;
            btn_s1_reg    <= '0;
            btn_s2_reg    <= '0;
            coin_s1_reg   <= '0;
            coin_s2_reg   <= '0;
            coin_prev_reg <= '0;
            rot_reg       <= 2'b00;
            mode8_reg     <= 1'b0;
        end else begin
            dir_s1_reg    <= dir_in;
            dir_s2_reg    <= dir_s1_reg;
            btn_s1_reg    <= btn_in;
            btn_s2_reg    <= btn_s1_reg;
            coin_s1_reg   <= coin_in;
            coin_s2_reg   <= coin_s1_reg;
            coin_prev_reg <= coin_s2_reg;
            rot_reg       <= rot;
            mode8_reg     <= mode8;
        end
    end

    // Any change of orientation or filter mode invalidates every held mask.
    assign force_open = (rot != rot_reg) || (mode8 != mode8_reg);

    genvar gi;

    for (gi = 0; gi < PLAYERS; gi++) begin : g_player
        logic [3:0]        cur;
        logic              pulse_reg;
        logic [COIN_W-1:0] coin_cnt_reg;

        assign cur = rotate_dir(rot_t'(rot), dir_s2_reg[4*gi +: 4]);

        dir_filter u_filter (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n),
            .cur        (cur),
            .dis        (dis),
            .mode8      (mode8),
            .force_open (force_open),
            .dir_out    (dir_out[4*gi +: 4])
        );

        // A new pulse can only start once the previous one has fully ended.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                pulse_reg    <= 1'b0;
                coin_cnt_reg <= '0;
            end else if (pulse_reg) begin
                if (coin_cnt_reg == '0) begin
                    pulse_reg <= 1'b0;
                end else begin
                    coin_cnt_reg <= coin_cnt_reg - 1'b1;
                end
            end else if (coin_s2_reg[gi] && !coin_prev_reg[gi]) begin
                pulse_reg    <= 1'b1;
                coin_cnt_reg <= COIN_W'(COIN_LEN - 1);
            end
        end

        assign coin_out[gi] = pulse_reg;
    end

    for (gi = 0; gi < NB; gi++) begin : g_btn
        logic deb_reg;

        if (DEB_CNT == 0) begin : g_pass
            assign deb_next[gi] = btn_s2_reg[gi];
        end else begin : g_count
            logic [DEB_W-1:0] cnt_reg;
            logic             hit;

            assign hit = (btn_s2_reg[gi] != deb_reg) && (cnt_reg == DEB_W'(DEB_CNT - 1));
            assign deb_next[gi] = hit ? btn_s2_reg[gi] : deb_reg;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg <= '0;
                end else if ((btn_s2_reg[gi] == deb_reg) || hit) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                deb_reg <= 1'b0;
            end else begin
                deb_reg <= deb_next[gi];
            end
        end

        assign deb_vec[gi] = deb_reg;
    end

`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
    localparam int unsigned AF_W = $clog2(AF_HALF + 1);

    logic [AF_W-1:0] af_cnt_reg;
    logic            af_tgl_reg;
    logic            af_restart;

    // Restart the phase on a fresh press so the first shot fires at once.
    assign af_restart = |(deb_next & ~deb_vec & af_sel);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_reg <= '0;
            af_tgl_reg <= 1'b1;
        end else if (af_restart) begin
            af_cnt_reg <= '0;
            af_tgl_reg <= 1'b1;
        end else if (af_cnt_reg == AF_W'(AF_HALF - 1)) begin
            af_cnt_reg <= '0;
            af_tgl_reg <= ~af_tgl_reg;
        end else begin
            af_cnt_reg <= af_cnt_reg + 1'b1;
        end
    end

    assign btn_out = deb_vec & ~(af_sel & {NB{~af_tgl_reg}});
`else
    logic unused_af_sel;
    assign unused_af_sel = ^af_sel;
    assign btn_out       = deb_vec;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expectations are queued with a due
// cycle when stimulus is applied and compared on the falling edge.
module tb_input_conditioner;

    localparam int PLAYERS  = 2;
    localparam int DEB_CNT  = 4;
    localparam int COIN_LEN = 5;
`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
    localparam int AF_HALF  = 3;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       dis     = 1'b0;
    logic [1:0] rot     = 2'b00;
    logic       mode8   = 1'b0;
    logic [7:0] dir_in  = 8'h00;
    logic [7:0] btn_in  = 8'h00;
    logic [1:0] coin_in = 2'b00;
    logic [7:0] af_sel  = 8'h00;
    logic [7:0] dir_out;
    logic [7:0] btn_out;
    logic [1:0] coin_out;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    int          sb_due[$];
    string       sb_tag[$];
    int          sb_sel[$];
    logic [15:0] sb_val[$];

    input_conditioner #(
        .PLAYERS  (PLAYERS),
        .DEB_CNT  (DEB_CNT),
        .COIN_LEN (COIN_LEN)
`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
        , .AF_HALF (AF_HALF)
`endif
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .dis      (dis),
        .rot      (rot),
        .mode8    (mode8),
        .dir_in   (dir_in),
        .btn_in   (btn_in),
        .coin_in  (coin_in),
        .af_sel   (af_sel),
        .dir_out  (dir_out),
        .btn_out  (btn_out),
        .coin_out (coin_out)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] observe(input int sel);
        logic [15:0] v;
        case (sel)
            0:       v = {8'h00, dir_out};
            1:       v = {8'h00, btn_out};
            2:       v = {14'h0, coin_out};
            default: v = {12'h0, dut.g_player[0].u_filter.mask_reg};
        endcase
        return v;
    endfunction

    task automatic expect_at(input int k, input string tag, input int sel, input logic [15:0] val);
        sb_due.push_back(cyc + k);
        sb_tag.push_back(tag);
        sb_sel.push_back(sel);
        sb_val.push_back(val);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    always @(negedge clk_sys) begin
        for (int i = sb_due.size() - 1; i >= 0; i--) begin
            if (sb_due[i] == cyc) begin
                check(sb_tag[i], observe(sb_sel[i]), sb_val[i]);
                $display("cycle %0d: %s sel=%0d exp=%h", cyc, sb_tag[i], sb_sel[i], sb_val[i]);
                sb_due.delete(i);
                sb_tag.delete(i);
                sb_sel.delete(i);
                sb_val.delete(i);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_dir",  observe(0), 16'h0000);
        check("rst_btn",  observe(1), 16'h0000);
        check("rst_coin", observe(2), 16'h0000);
        check("rst_mask", observe(3), 16'h000F);
        reset_n = 1'b1;
        tick(4);

        // 4-way: last pressed wins, release reverts to the held direction
        dir_in = 8'h08;
        expect_at(2, "up_early", 0, 16'h00);
        expect_at(3, "up", 0, 16'h08);
        tick(10);
        dir_in = 8'h0A;
        expect_at(2, "left_early", 0, 16'h08);
        expect_at(3, "left_wins", 0, 16'h02);
        tick(6);
        dir_in = 8'h08;
        expect_at(3, "left_rel", 0, 16'h08);
        tick(6);
        dir_in = 8'h00;
        expect_at(3, "all_rel", 0, 16'h00);
        tick(6);

        dir_in = 8'h09;
        expect_at(3, "up_right", 0, 16'h08);
        expect_at(3, "mask_up", 3, 16'h08);
        tick(6);
        dir_in = 8'h00;
        expect_at(3, "ur_rel", 0, 16'h00);
        expect_at(3, "mask_open", 3, 16'h0F);
        tick(6);

        dir_in = 8'h41;
        expect_at(3, "two_players", 0, 16'h41);
        tick(6);
        dir_in = 8'h00;
        tick(6);

        // bypass keeps simultaneous directions
        dis = 1'b1;
        tick(2);
        dir_in = 8'h0C;
        expect_at(3, "dis_pass", 0, 16'h0C);
        tick(6);
        dir_in = 8'h00;
        tick(6);
        dis = 1'b0;
        tick(2);

        // 8-way SOCD and rotation
        mode8 = 1'b1;
        tick(4);
        dir_in = 8'h0B;
        expect_at(3, "socd_lr", 0, 16'h08);
        tick(6);
        dir_in = 8'h0E;
        expect_at(3, "socd_ud", 0, 16'h02);
        tick(6);
        dir_in = 8'h00;
        tick(2);
        rot = 2'b01;
        tick(4);
        dir_in = 8'h08;
        expect_at(3, "rot_cw", 0, 16'h01);
        tick(6);
        rot = 2'b10;
        expect_at(1, "rot_ccw", 0, 16'h02);
        tick(6);
        dir_in = 8'h00;
        rot    = 2'b00;
        mode8  = 1'b0;
        tick(6);

        // debounce
        btn_in = 8'h01;
        expect_at(6, "glitch3", 1, 16'h00);
        expect_at(9, "glitch3_late", 1, 16'h00);
        tick(3);
        btn_in = 8'h00;
        tick(10);
        btn_in = 8'h01;
        expect_at(5, "deb_early", 1, 16'h00);
        expect_at(6, "deb_rise", 1, 16'h01);
        tick(6);
        btn_in = 8'h00;
        expect_at(5, "deb_hold", 1, 16'h01);
        expect_at(6, "deb_fall", 1, 16'h00);
        tick(10);
        btn_in = 8'h20;
        expect_at(6, "glitch4", 1, 16'h20);
        tick(4);
        btn_in = 8'h00;
        expect_at(6, "glitch4_fall", 1, 16'h00);
        tick(10);

        // coin: held input gives exactly one pulse
        coin_in = 2'b01;
        for (int k = 1; k <= 12; k++)
            expect_at(k, "coin_held", 2, (k >= 3 && k <= 7) ? 16'h1 : 16'h0);
        tick(20);
        coin_in = 2'b00;
        tick(4);

        // coin: re-edge landing on the final pulse cycle is ignored
        coin_in = 2'b01;
        for (int k = 1; k <= 14; k++)
            expect_at(k, "coin_reedge", 2, (k >= 3 && k <= 7) ? 16'h1 : 16'h0);
        tick(2);
        coin_in = 2'b00;
        tick(3);
        coin_in = 2'b01;
        tick(10);
        coin_in = 2'b00;
        tick(4);

        coin_in = 2'b10;
        expect_at(3, "coin_p1", 2, 16'h2);
        expect_at(8, "coin_p1_end", 2, 16'h0);
        tick(10);
        coin_in = 2'b00;
        tick(4);

        // asynchronous reset mid-pulse
        btn_in = 8'h01;
        tick(8);
        coin_in = 2'b01;
        tick(5);
        check("coin_pre_rst", observe(2), 16'h1);
        reset_n = 1'b0;
        #1;
        check("coin_rst", observe(2), 16'h0);
        check("btn_rst",  observe(1), 16'h0);
        coin_in = 2'b00;
        btn_in  = 8'h00;
        tick(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            expect_at(k, "post_rst_coin", 2, 16'h0);
            expect_at(k, "post_rst_btn", 1, 16'h0);
        end
        tick(12);

`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
        af_sel = 8'h01;
        btn_in = 8'h01;
        for (int k = 5; k <= 14; k++)
            expect_at(k, "autofire", 1, (k >= 6 && ((k - 6) / 3) % 2 == 0) ? 16'h01 : 16'h00);
        tick(16);
        btn_in = 8'h00;
        tick(10);
        af_sel = 8'h00;
        tick(4);
`endif

        tick(20);
        for (int i = 0; i < sb_due.size(); i++) begin
            n_checks++;
            $display("FAIL %s: got no sample expected check at cycle %0d", sb_tag[i], sb_due[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
